dm_store_buffer: RTL and testbench
==================================

Name: dm_store_buffer

Overview:
- Store buffer between the EX/MEM pipeline register and the data memory write port.
- Queues sw requests (address, data, PC) in a small circular FIFO and drains one per cycle into the DM when the port is granted.
- Provides same-cycle load bypass so a lw that hits a buffered, not-yet-written store sees the youngest buffered value.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, at least 2.
- PTR_W, 2, pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- st_valid  input  1  store request from MEM stage.
- st_addr  input  32  byte address of the store (ALU result).
- st_data  input  32  store data.
- st_pc  input  32  PC of the sw instruction, carried for the write trace.
- st_ready  output  1  buffer can accept a store this cycle.
- ld_addr  input  32  byte address of the current load.
- ld_hit  output  1  ld_addr word matches a buffered store.
- ld_data  output  32  data of the youngest matching buffered store; 0 when no hit.
- dm_ready  input  1  DM write port granted this cycle.
- dm_we  output  1  DM write strobe (drives DM sw).
- dm_addr  output  32  head entry address.
- dm_wdata  output  32  head entry data.
- dm_pc  output  32  head entry PC.
- count  output  PTR_W+1  number of valid entries.
- empty  output  1  count == 0.

Behaviour:
- Storage: DEPTH entries of {addr, data, pc, valid}, plus head, tail and count registers.
- Reset (synchronous, active-high, at posedge):
  - head, tail and count go to 0; all valid bits are cleared.
  - Entry payloads are don't-care.
  - Pending stores are discarded and no DM write occurs for them.
- Output values after reset:
  - st_ready = 1, empty = 1, count = 0.
  - dm_we = 0, ld_hit = 0, ld_data = 0.
- st_ready = (count < DEPTH). It depends on registered count only; a full buffer refuses a store even in a cycle where it drains.
- Enqueue:
  - Occurs when st_valid && st_ready.
  - Writes the entry at tail and sets its valid bit.
  - tail increments modulo DEPTH; the pointer wraps naturally at PTR_W bits.
  - st_valid while st_ready = 0 is ignored. The producer must hold the request; the pipeline stalls on !st_ready.
- Drain:
  - dm_we = (count != 0) && dm_ready. This is combinational from registers and dm_ready.
  - dm_addr, dm_wdata and dm_pc always show the head entry; they are 0 when empty.
  - When dm_we = 1, at posedge: clear the valid bit at head, and head increments modulo DEPTH.
  - Each buffered store produces exactly one DM write.
  - DM writes occur in enqueue order.
- Count update:
  - +1 on enqueue only.
  - −1 on drain only.
  - Unchanged when enqueue and drain happen in the same cycle.
  - This allows a simultaneous enqueue and drain at any count from 1 to DEPTH−1.
- Load bypass:
  - Purely combinational.
  - Compares ld_addr[31:2] against addr[31:2] of every valid entry; bits [1:0] are ignored.
  - If several entries match, the youngest wins (the one closest to tail−1 going backwards).
  - The head entry still counts for a match in the cycle it drains.
  - A store being enqueued in the same cycle is not visible. Same-cycle sw→lw to the same word is resolved by the hazard unit, not here.
- No read-modify-write and no byte enables: whole-word stores only.
- empty = (count == 0).
- No state changes other than those listed above.

Test Plan:
- Single store drain: reset, then st_valid = 1 with addr 0x0000_0010, data 0xDEAD_BEEF, dm_ready = 1. Required: count = 1 next cycle, dm_we = 1 with dm_addr 0x10 and dm_wdata 0xDEADBEEF; the following cycle count = 0 and empty = 1.
- Fill to full: dm_ready = 0, enqueue 4 stores to 0x0, 0x4, 0x8, 0xC. Required: count = 4, st_ready = 0; a 5th st_valid is ignored and count stays 4. Then dm_ready = 1 for 4 cycles. Required: DM writes in order 0x0, 0x4, 0x8, 0xC.
- Bypass youngest: enqueue 0x20←0x1111 then 0x20←0x2222 with dm_ready = 0, and ld_addr = 0x23. Required: ld_hit = 1, ld_data = 0x2222. With ld_addr = 0x24: ld_hit = 0, ld_data = 0.
- Simultaneous enqueue and drain: with count = 2 and dm_ready = 1, enqueue 0x40←0x5. Required: count stays 2, the head advances, and the new entry is at the tail.
- Wrap-around: keep dm_ready = 1 and stream 10 consecutive stores at one per cycle. Required: 10 DM writes, in order, with correct data; head and tail wrap without loss.
- Reset mid-operation: with count = 3 and dm_ready = 0, assert reset for 1 cycle, then set dm_ready = 1. Required: count = 0, st_ready = 1, and dm_we stays 0 because the discarded stores are never written.

Source files
------------

// File: rtl/dm_store_buffer.sv
// Store buffer between EX/MEM and the data-memory write port: in-order FIFO of
// word stores with a same-cycle load bypass returning the youngest buffered match.
module dm_store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_st_valid,
  input  logic [31:0]      i_st_addr,
  input  logic [31:0]      i_st_data,
  input  logic [31:0]      i_st_pc,
  output logic             o_st_ready,
  input  logic [31:0]      i_ld_addr,
  output logic             o_ld_hit,
  output logic [31:0]      o_ld_data,
  input  logic             i_dm_ready,
  output logic             o_dm_we,
  output logic [31:0]      o_dm_addr,
  output logic [31:0]      o_dm_wdata,
  output logic [31:0]      o_dm_pc,
  output logic [PTR_W:0]   o_count,
  output logic             o_empty
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]      r_addr [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [31:0]      r_pc   [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic        w_nonempty;
  logic        w_enq;
  logic        w_deq;
  logic        w_ld_hit;
  logic [31:0] w_ld_data;
  logic        w_unused;

  assign w_nonempty = (r_count != '0);
  assign o_st_ready = (r_count < FULL_CNT);
  assign w_enq      = i_st_valid && o_st_ready;
  assign w_deq      = w_nonempty && i_dm_ready;

  assign o_dm_we    = w_deq;
  assign o_dm_addr  = w_nonempty ? r_addr[r_head] : '0;
  assign o_dm_wdata = w_nonempty ? r_data[r_head] : '0;
  assign o_dm_pc    = w_nonempty ? r_pc[r_head]   : '0;
  assign o_count    = r_count;
  assign o_empty    = !w_nonempty;
  assign o_ld_hit   = w_ld_hit;
  assign o_ld_data  = w_ld_data;

  // Byte offset of the load is irrelevant for whole-word matching.
  assign w_unused = ^i_ld_addr[1:0];

  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin : p_bypass
    logic [PTR_W-1:0] idx;
    idx       = r_head;
    w_ld_hit  = 1'b0;
    w_ld_data = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      idx = r_head + PTR_W'(i);
      if (r_valid[idx] && (r_addr[idx][31:2] == i_ld_addr[31:2])) begin
        w_ld_hit  = 1'b1;
        w_ld_data = r_data[idx];
      end
    end
  end

  // Control state: pointers, occupancy and valid bits.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_enq) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PTR_W'(1);
      end
      if (w_deq) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      if (w_enq && !w_deq) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_enq && w_deq) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Payload storage needs no reset; valid bits qualify every use.
  always_ff @(posedge i_clk) begin
    if (!i_reset && w_enq) begin
      r_addr[r_tail] <= i_st_addr;
      r_data[r_tail] <= i_st_data;
      r_pc[r_tail]   <= i_st_pc;
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Self-checking bench for dm_store_buffer: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_dm_store_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             st_valid;
  logic [31:0]      st_addr, st_data, st_pc;
  logic             st_ready;
  logic [31:0]      ld_addr;
  logic             ld_hit;
  logic [31:0]      ld_data;
  logic             dm_ready;
  logic             dm_we;
  logic [31:0]      dm_addr, dm_wdata, dm_pc;
  logic [PTR_W:0]   count;
  logic             empty;

  always #5 clk = ~clk;

  dm_store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_st_valid(st_valid), .i_st_addr(st_addr), .i_st_data(st_data), .i_st_pc(st_pc),
    .o_st_ready(st_ready),
    .i_ld_addr(ld_addr), .o_ld_hit(ld_hit), .o_ld_data(ld_data),
    .i_dm_ready(dm_ready), .o_dm_we(dm_we), .o_dm_addr(dm_addr),
    .o_dm_wdata(dm_wdata), .o_dm_pc(dm_pc),
    .o_count(count), .o_empty(empty)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc;
  } st_t;

  st_t mq[$];
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then advance.
  task automatic step(input logic rst, input logic sv, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] la, input logic dr);
    logic        e_rdy, e_we, e_hit;
    logic [31:0] e_ld, e_addr, e_data, e_pc;
    st_t         ent;
    @(negedge clk);
    reset    = rst;
    st_valid = sv;
    st_addr  = a;
    st_data  = d;
    st_pc    = a ^ 32'h0040_0000;
    ld_addr  = la;
    dm_ready = dr;
    #1;
    e_rdy = (mq.size() < int'(DEPTH));
    e_we  = (mq.size() != 0) && dr;
    e_hit = 1'b0;
    e_ld  = '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].addr[31:2] == la[31:2]) begin
        e_hit = 1'b1;
        e_ld  = mq[i].data;
        break;
      end
    end
    e_addr = (mq.size() != 0) ? mq[0].addr : 32'h0;
    e_data = (mq.size() != 0) ? mq[0].data : 32'h0;
    e_pc   = (mq.size() != 0) ? mq[0].pc   : 32'h0;
    check("st_ready", 32'(st_ready), 32'(e_rdy));
    check("count",    32'(count),    32'(mq.size()));
    check("empty",    32'(empty),    32'(mq.size() == 0));
    check("dm_we",    32'(dm_we),    32'(e_we));
    check("dm_addr",  dm_addr,       e_addr);
    check("dm_wdata", dm_wdata,      e_data);
    check("dm_pc",    dm_pc,         e_pc);
    check("ld_hit",   32'(ld_hit),   32'(e_hit));
    check("ld_data",  ld_data,       e_ld);
    @(posedge clk);
    if (rst) begin
      mq.delete();
    end else begin
      if (e_we) void'(mq.pop_front());
      if (sv && e_rdy) begin
        ent.addr = a;
        ent.data = d;
        ent.pc   = a ^ 32'h0040_0000;
        mq.push_back(ent);
      end
    end
  endtask

  task automatic idle(input logic dr);
    step(1'b0, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFF0, dr);
  endtask

  initial begin
    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_pc = '0;
    ld_addr = '0; dm_ready = 1'b0;
    repeat (2) @(posedge clk);
    mq.delete();

    // Reset state, then single store drained immediately.
    idle(1'b0);
    step(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Fill to full, refused fifth store, then in-order drain.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'(i * 4), 32'hA000 + 32'(i), 32'h100, 1'b0);
    step(1'b0, 1'b1, 32'h50, 32'hBAD, 32'h100, 1'b0);
    step(1'b0, 1'b1, 32'h54, 32'hBAD2, 32'h8, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Youngest-wins bypass and word-granular miss.
    step(1'b0, 1'b1, 32'h20, 32'h1111, 32'h23, 1'b0);
    step(1'b0, 1'b1, 32'h20, 32'h2222, 32'h23, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 32'h23, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 32'h24, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 32'h20, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 32'h22, 1'b1);
    idle(1'b0);

    // Simultaneous enqueue and drain at count = 2.
    step(1'b0, 1'b1, 32'h30, 32'h3, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h34, 32'h4, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h40, 32'h5, 32'h40, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 32'h40, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Streaming ten stores through with the port always granted.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 32'h200 + 32'(i * 4), $urandom, 32'h200, 1'b1);
    for (int i = 0; i < 2; i++) idle(1'b1);

    // Reset with three pending stores discards them.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h60 + 32'(i * 4), 32'h600 + 32'(i), 32'h60, 1'b0);
    step(1'b1, 1'b0, 32'h0, 32'h0, 32'h60, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 32'h64, 1'b1);
    idle(1'b1);

    // Random traffic over a small address window to provoke hits and wrap.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)),
           {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))},
           $urandom,
           {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))},
           ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 5; i++) idle(1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
